// File: rtl/hdmi_i2c_cmd_pkg.sv
// hdmi_i2c_pkg: FSM states, status bit positions and cmd_word fields shared by hdmi_i2c_cmd.
// Read-only states exist only when HDMI_I2C_READ_EN is defined.
package hdmi_i2c_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      SHIFT  = 3'd2,
      ACK    = 3'd3,
      STOP   = 3'd4
`ifdef HDMI_I2C_READ_EN
      ,
      RSTART = 3'd5,
      RSHIFT = 3'd6,
      MACK   = 3'd7
`endif
   } state_t;

   localparam int BUSY_BIT   = 0;
   localparam int ACKERR_BIT = 1;
   localparam int DONE_BIT   = 2;
   localparam int RDATA_LSB  = 8;

   localparam int GO_BIT     = 31;
   localparam int READ_BIT   = 30;
   localparam int REG_LSB    = 16;
   localparam int DATA_LSB   = 8;

endpackage

// File: rtl/hdmi_i2c_cmd_tick_gen.sv
// i2c_tick_gen: quarter-bit tick every DIV clocks; held cleared while disabled so phase starts at launch.
module i2c_tick_gen
   import hdmi_i2c_pkg::*;
#(
   parameter int DIV = 31
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int W = DIV > 1 ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = en && cnt == W'(DIV - 1);

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         cnt <= '0;
      else if (!en || tick)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);

endmodule

// File: rtl/hdmi_i2c_cmd.sv
// hdmi_i2c_cmd: PIO command word to one I2C register write; HDMI_I2C_READ_EN adds a register read.
// Each bit is 4 ticks: q0 set SDA, q1 release SCL, q2 sample SDA, q3 pull SCL low.
module hdmi_i2c_cmd
   import hdmi_i2c_pkg::*;
#(
   parameter int         CLK_HZ   = 50_000_000,
   parameter int         I2C_HZ   = 400_000,
   parameter logic [6:0] DEV_ADDR = 7'h39
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cmd_word,
   input  logic        sda_in,
   output logic        scl_oe,
   output logic        sda_oe,
   output logic [31:0] status
);

   localparam int DIV = CLK_HZ / (4 * I2C_HZ);

   state_t     state, state_n;
   logic       go_q, tick, launch, last;
   logic       ack_err, err_n, done, done_n, scl_n, sda_n;
   logic [1:0] q, byte_cnt, byte_n;
   logic [2:0] bit_cnt, bit_n;
   logic [7:0] reg_q, data_q, tx;
   logic       unused_cmd;
`ifdef HDMI_I2C_READ_EN
   logic       rd;
   logic [7:0] rx, rx_n, rdata;
   assign unused_cmd = ^{cmd_word[29:24], cmd_word[7:0]};
   assign tx = byte_cnt == 2'd0 ? {DEV_ADDR, 1'b0} : byte_cnt == 2'd1 ? reg_q :
               rd ? {DEV_ADDR, 1'b1} : data_q;
`else
   assign unused_cmd = ^{cmd_word[30:24], cmd_word[7:0]};
   assign tx = byte_cnt == 2'd0 ? {DEV_ADDR, 1'b0} : byte_cnt == 2'd1 ? reg_q : data_q;
`endif

   assign launch = cmd_word[GO_BIT] && !go_q && state == IDLE;
   assign last   = tick && q == 2'd3;

   i2c_tick_gen #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state != IDLE),
      .tick    (tick)
   );

   always_comb begin
      state_n = state;
      scl_n   = scl_oe;
      sda_n   = sda_oe;
      bit_n   = bit_cnt;
      byte_n  = byte_cnt;
      err_n   = ack_err;
      done_n  = done;
`ifdef HDMI_I2C_READ_EN
      rx_n    = rx;
`endif
      if (launch) begin
         state_n = START;
         err_n   = 1'b0;
         done_n  = 1'b0;
         bit_n   = 3'd7;
         byte_n  = 2'd0;
      end else if (tick) begin
         scl_n = q == 2'd1 ? 1'b0 : (q == 2'd3 && state != STOP) ? 1'b1 : scl_oe;
         case (state)
            START: begin
               sda_n = q == 2'd0 ? 1'b0 : q == 2'd2 ? 1'b1 : sda_oe;
               if (last) state_n = SHIFT;
            end
            SHIFT: begin
               if (q == 2'd0) sda_n = ~tx[bit_cnt];
               if (last) begin
                  bit_n   = bit_cnt - 3'd1;
                  state_n = bit_cnt == 3'd0 ? ACK : SHIFT;
               end
            end
            ACK: begin
               if (q == 2'd0) sda_n = 1'b0;
               if (q == 2'd2) err_n = ack_err | sda_in;
               if (last) begin
                  byte_n = byte_cnt + 2'd1;
`ifdef HDMI_I2C_READ_EN
                  state_n = ack_err ? STOP : !rd ? (byte_cnt == 2'd2 ? STOP : SHIFT) :
                            byte_cnt == 2'd0 ? SHIFT : byte_cnt == 2'd1 ? RSTART : RSHIFT;
`else
                  state_n = (ack_err || byte_cnt == 2'd2) ? STOP : SHIFT;
`endif
               end
            end
            STOP: begin
               sda_n = q == 2'd0 ? 1'b1 : q == 2'd2 ? 1'b0 : sda_oe;
               if (last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
`ifdef HDMI_I2C_READ_EN
            RSTART: begin
               sda_n = q == 2'd0 ? 1'b0 : q == 2'd2 ? 1'b1 : sda_oe;
               if (last) state_n = SHIFT;
            end
            RSHIFT: begin
               if (q == 2'd0) sda_n = 1'b0;
               if (q == 2'd2) rx_n = {rx[6:0], sda_in};
               if (last) begin
                  bit_n   = bit_cnt - 3'd1;
                  state_n = bit_cnt == 3'd0 ? MACK : RSHIFT;
               end
            end
            MACK: begin
               if (q == 2'd0) sda_n = 1'b0;
               if (last) state_n = STOP;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= IDLE;
         go_q     <= 1'b0;
         q        <= 2'd0;
         bit_cnt  <= 3'd7;
         byte_cnt <= 2'd0;
         reg_q    <= 8'h00;
         data_q   <= 8'h00;
         ack_err  <= 1'b0;
         done     <= 1'b0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
`ifdef HDMI_I2C_READ_EN
         rd       <= 1'b0;
         rx       <= 8'h00;
         rdata    <= 8'h00;
`endif
      end else begin
         state    <= state_n;
         go_q     <= cmd_word[GO_BIT];
         q        <= launch ? 2'd0 : tick ? q + 2'd1 : q;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         ack_err  <= err_n;
         done     <= done_n;
         scl_oe   <= scl_n;
         sda_oe   <= sda_n;
         if (launch) begin
            reg_q  <= cmd_word[REG_LSB +: 8];
            data_q <= cmd_word[DATA_LSB +: 8];
         end
`ifdef HDMI_I2C_READ_EN
         if (launch) rd <= cmd_word[READ_BIT];
         rx <= rx_n;
         // Only a completed, fully acknowledged read publishes a byte.
         if (last && state == STOP) rdata <= (rd && !ack_err) ? rx : 8'h00;
`endif
      end

   always_comb begin
      status             = '0;
      status[BUSY_BIT]   = state != IDLE;
      status[ACKERR_BIT] = ack_err;
      status[DONE_BIT]   = done;
`ifdef HDMI_I2C_READ_EN
      status[RDATA_LSB +: 8] = rdata;
`endif
   end

endmodule

// File: tb/tb_hdmi_i2c_cmd.sv
// tb_hdmi_i2c_cmd: bench with an open-drain bus, I2C slave/monitor and a byte-level frame model.
module tb_hdmi_i2c_cmd;

   localparam int         CLK_HZ = 50_000_000;
   localparam int         I2C_HZ = 400_000;
   localparam int         DIV    = CLK_HZ / (4 * I2C_HZ);
   localparam logic [6:0] DEV    = 7'h39;
`ifdef HDMI_I2C_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   logic        clk = 1'b0, reset_n = 1'b0, slave_low = 1'b0;
   logic        scl_oe, sda_oe, scl, sda, sda_in;
   logic [31:0] cmd_word = 32'h0, status;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   assign scl    = ~scl_oe;
   assign sda    = ~sda_oe & ~slave_low;
   assign sda_in = sda;

   hdmi_i2c_cmd #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .DEV_ADDR(DEV)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd_word (cmd_word),
      .sda_in   (sda_in),
      .scl_oe   (scl_oe),
      .sda_oe   (sda_oe),
      .status   (status)
   );

   // Bus monitor and slave: logs every byte with its 9th bit, ACKs master bytes, serves read data.
   int         nbits = 0, n_start = 0, n_stop = 0, nack_k = -1, p, k;
   logic       rmode = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
   logic [7:0] sh = 8'h0, slave_rdata = 8'h0;
   logic [7:0] log_b[$];
   logic       log_a[$];

   always @(scl, sda) begin
      if (scl && scl_p && sda_p && !sda) begin
         n_start++; nbits = 0; rmode = 1'b0; slave_low = 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
         n_stop++; slave_low = 1'b0;
      end else if (scl && !scl_p) begin
         if (nbits % 9 < 8) sh = {sh[6:0], sda};
         else begin
            log_b.push_back(sh); log_a.push_back(sda);
            if (nbits / 9 == 0) rmode = sh[0];
         end
         nbits++;
      end else if (!scl && scl_p) begin
         p = nbits % 9; k = nbits / 9;
         if (p == 8) slave_low = !(rmode && k == 1) && k != nack_k;
         else slave_low = rmode && k == 1 && !slave_rdata[7 - p];
      end
      scl_p = scl; sda_p = sda;
   end

   // Expected bus bytes, busy length and final status from the frame rules.
   function automatic void model(input logic [31:0] c, input int nk, input logic [7:0] rv,
                                 output logic [31:0] eb, output int en, output int ecyc,
                                 output logic [31:0] est);
      logic       rd;
      logic [7:0] mb[3];
      int         bits;
      rd    = READ_EN && c[30];
      mb[0] = {DEV, 1'b0};
      mb[1] = c[23:16];
      mb[2] = rd ? {DEV, 1'b1} : c[15:8];
      eb = 32'h0; en = 0; bits = 2; est = 32'h4;
      for (int i = 0; i < 3; i++) begin
         eb = {eb[23:0], mb[i]}; en++;
         bits += 9 + ((rd && i == 2) ? 1 : 0);
         if (i == nk) begin est = 32'h6; break; end
      end
      if (rd && est == 32'h4) begin
         eb = {eb[23:0], rv}; en++; bits += 9; est = {16'h0, rv, 8'h04};
      end
      ecyc = bits * 4 * DIV;
   endfunction

   function automatic logic [31:0] got_bytes(input int base);
      logic [31:0] v;
      v = 32'h0;
      for (int i = base; i < log_b.size(); i++) v = {v[23:0], log_b[i]};
      return v;
   endfunction

   task automatic do_frame(input logic [31:0] c, output int cyc, output logic fb);
      @(negedge clk); cmd_word = {1'b0, c[30:0]};
      @(negedge clk); cmd_word = c;
      @(negedge clk); fb = status[0];
      cyc = 0;
      while (status[0] && cyc < 20000) begin cyc++; @(negedge clk); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl: got %b want 0", scl_oe); end
      n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda: got %b want 0", sda_oe); end
      n_checks++; if (status !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", status); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      int base, s0, p0, cyc, en, ecyc; logic fb; logic [31:0] eb, est;
      base = log_b.size(); s0 = n_start; p0 = n_stop;
      model(32'h80411000, -1, 8'h0, eb, en, ecyc, est);
      do_frame(32'h80411000, cyc, fb);
      n_checks++; if (fb !== 1'b1) begin n_fail++; $display("FAIL write_busy_rise: got %b want 1", fb); end
      n_checks++; if (cyc != ecyc) begin n_fail++; $display("FAIL write_len: got %0d want %0d", cyc, ecyc); end
      n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
         n_fail++; $display("FAIL write_bytes: got %0d/%h want %0d/%h", log_b.size() - base, got_bytes(base), en, eb); end
      n_checks++; if (status !== est) begin n_fail++; $display("FAIL write_status: got %h want %h", status, est); end
      n_checks++; if (n_start - s0 != 1 || n_stop - p0 != 1) begin
         n_fail++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", n_start - s0, n_stop - p0); end
   endtask

   task automatic test_nack();
      int base, p0, cyc, en, ecyc; logic fb; logic [31:0] eb, est;
      nack_k = 0;
      base = log_b.size(); p0 = n_stop;
      model(32'h80411000, 0, 8'h0, eb, en, ecyc, est);
      do_frame(32'h80411000, cyc, fb);
      nack_k = -1;
      n_checks++; if (cyc != ecyc) begin n_fail++; $display("FAIL nack_len: got %0d want %0d", cyc, ecyc); end
      n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
         n_fail++; $display("FAIL nack_bytes: got %0d/%h want %0d/%h", log_b.size() - base, got_bytes(base), en, eb); end
      n_checks++; if (status !== est || n_stop - p0 != 1) begin
         n_fail++; $display("FAIL nack_status: got %h stops %0d want %h stops 1", status, n_stop - p0, est); end
   endtask

   task automatic test_busy_repulse();
      int base, s0, cyc, en, ecyc; logic [31:0] eb, est;
      base = log_b.size(); s0 = n_start;
      model(32'h80411000, -1, 8'h0, eb, en, ecyc, est);
      @(negedge clk); cmd_word = 32'h0;
      @(negedge clk); cmd_word = 32'h80411000;
      repeat (500) @(negedge clk);
      cmd_word = 32'h0;
      @(negedge clk); cmd_word = 32'h80AA5500;
      cyc = 0;
      while (status[0] && cyc < 20000) begin cyc++; @(negedge clk); end
      repeat (600) @(negedge clk);
      n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
         n_fail++; $display("FAIL repulse_bytes: got %0d/%h want %0d/%h", log_b.size() - base, got_bytes(base), en, eb); end
      n_checks++; if (status !== est || n_start - s0 != 1) begin
         n_fail++; $display("FAIL repulse_no_second: got %h starts %0d want %h starts 1", status, n_start - s0, est); end
   endtask

   task automatic test_reset_mid();
      int base, cyc, en, ecyc; logic fb; logic [31:0] c, eb, est;
      @(negedge clk); cmd_word = 32'h0;
      @(negedge clk); cmd_word = 32'h80411000;
      repeat (12 * 4 * DIV + 40) @(negedge clk);
      n_checks++; if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL midframe_scl: got %b want 1", scl_oe); end
      #3 reset_n = 1'b0; cmd_word = 32'h0;
      #1;
      n_checks++; if ({scl_oe, sda_oe} !== 2'b00 || status !== 32'h0) begin
         n_fail++; $display("FAIL midreset: got scl %b sda %b status %h want 0 0 0", scl_oe, sda_oe, status); end
      @(negedge clk); reset_n = 1'b1;
      c = $urandom; c[31] = 1'b1; if (READ_EN) c[30] = 1'b0;
      base = log_b.size();
      model(c, -1, 8'h0, eb, en, ecyc, est);
      do_frame(c, cyc, fb);
      n_checks++; if (cyc != ecyc || status !== est) begin
         n_fail++; $display("FAIL after_reset_frame: got len %0d status %h want %0d %h", cyc, status, ecyc, est); end
      n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
         n_fail++; $display("FAIL after_reset_bytes: got %0d/%h want %0d/%h", log_b.size() - base, got_bytes(base), en, eb); end
   endtask

   task automatic test_random();
      int base, cyc, en, ecyc, nk; logic fb; logic [31:0] c, eb, est;
      for (int i = 0; i < 6; i++) begin
         c = $urandom; c[31] = 1'b1; if (READ_EN) c[30] = 1'b0;
         nk = $urandom_range(0, 3); if (nk == 3) nk = -1;
         nack_k = nk;
         base = log_b.size();
         model(c, nk, 8'h0, eb, en, ecyc, est);
         do_frame(c, cyc, fb);
         n_checks++; if (cyc != ecyc) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", i, cyc, ecyc); end
         n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
            n_fail++; $display("FAIL rand%0d_bytes: got %0d/%h want %0d/%h", i, log_b.size() - base, got_bytes(base), en, eb); end
         n_checks++; if (status !== est) begin n_fail++; $display("FAIL rand%0d_status: got %h want %h", i, status, est); end
      end
      nack_k = -1;
   endtask

   task automatic test_read();
      int base, s0, cyc, en, ecyc; logic fb; logic [31:0] eb, est;
      slave_rdata = 8'h7A; nack_k = -1;
      base = log_b.size(); s0 = n_start;
      model(32'hC0000000, -1, 8'h7A, eb, en, ecyc, est);
      do_frame(32'hC0000000, cyc, fb);
      n_checks++; if (cyc != ecyc) begin n_fail++; $display("FAIL read_len: got %0d want %0d", cyc, ecyc); end
      n_checks++; if (log_b.size() - base != en || got_bytes(base) !== eb) begin
         n_fail++; $display("FAIL read_bytes: got %0d/%h want %0d/%h", log_b.size() - base, got_bytes(base), en, eb); end
      n_checks++; if (status !== est) begin n_fail++; $display("FAIL read_status: got %h want %h", status, est); end
      n_checks++; if (n_start - s0 != (READ_EN ? 2 : 1)) begin
         n_fail++; $display("FAIL read_starts: got %0d want %0d", n_start - s0, READ_EN ? 2 : 1); end
      n_checks++; if (log_a.size() == 0 || log_a[log_a.size() - 1] !== READ_EN) begin
         n_fail++; $display("FAIL read_last_ack: got %b want %b", log_a.size() ? log_a[log_a.size() - 1] : 1'bx, READ_EN); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_nack();
      test_busy_repulse();
      test_reset_mid();
      test_random();
      test_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
